// File: rtl/axis_keep_packer.sv
// -----------------------------------------------------------------------------
// axis_keep_packer
//
// AXI-Stream lane packer. Input beats may carry any tkeep pattern (sparse,
// unaligned head/tail, all-zero). Enabled lanes are compacted in ascending
// lane order and appended to a residue accumulator. Output beats are dense:
// tkeep is contiguous from lane 0 and every beat except the last beat of a
// packet is full.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_axis_*              input stream (tvalid/tready/tdata/tkeep/tuser/tlast)
//   m_axis_*              packed output stream, single register stage
//   stat_pkt_done         one-cycle pulse after an output tlast beat handshakes
//   stat_pkt_lanes        lane count of the last completed packet (saturating)
// -----------------------------------------------------------------------------
module axis_keep_packer #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int KEEP_W = DATA_W / LANE_W,
    parameter int USER_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              stat_pkt_done,
    output logic [CNT_W-1:0]  stat_pkt_lanes
);

    // cnt holds 0..KEEP_W-1 lanes; total spans 0..2*KEEP_W-1.
    localparam int CW = $clog2(KEEP_W + 1);
    localparam int TW = $clog2(2 * KEEP_W + 1);
    localparam int IW = (KEEP_W > 1) ? $clog2(2 * KEEP_W) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    typedef logic [KEEP_W-1:0][LANE_W-1:0] lanes_t;

    function automatic logic [TW-1:0] popcount(input logic [KEEP_W-1:0] keep);
        logic [TW-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {{(TW-1){1'b0}}, keep[i]};
        end
        return n;
    endfunction

    // Contiguous-from-LSB keep mask with n lanes set (n <= KEEP_W).
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [TW-1:0] n);
        logic [KEEP_W-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    state_t                        state_r;
    lanes_t                        acc_r;
    logic [CW-1:0]                 cnt_r;
    logic                          sop_r;
    logic [USER_W-1:0]             user_r;
    logic [CNT_W-1:0]              pkt_cnt_r;
    logic [CNT_W-1:0]              last_lanes_r;

    lanes_t                        in_lanes_s;
    logic [2*KEEP_W-1:0][LANE_W-1:0] comb_s;
    logic [IW-1:0]                 idx_s;
    logic [TW-1:0]                 pop_s;
    logic [TW-1:0]                 total_s;
    logic                          free_s;
    logic                          accept_s;
    logic                          tail_hs_s;
    logic [USER_W-1:0]             user_s;
    logic [CNT_W:0]                pkt_sum_s;
    logic [CNT_W-1:0]              pkt_next_s;

    assign in_lanes_s    = s_axis_tdata;
    assign free_s        = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state_r == RUN) && free_s;
    assign accept_s      = s_axis_tvalid && s_axis_tready;
    assign tail_hs_s     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign pop_s         = popcount(s_axis_tkeep);
    assign total_s       = TW'(cnt_r) + pop_s;
    // First beat of a packet supplies tuser; later beats reuse the latched copy.
    assign user_s        = sop_r ? s_axis_tuser : user_r;
    assign pkt_sum_s     = {1'b0, pkt_cnt_r} + (CNT_W+1)'(pop_s);
    assign pkt_next_s    = pkt_sum_s[CNT_W] ? {CNT_W{1'b1}} : pkt_sum_s[CNT_W-1:0];

    // Compaction: held residue lanes first, then enabled input lanes in order.
    // Lanes above the total stay zero, so slices of comb_s are already clean.
    always_comb begin
        comb_s          = '0;
        comb_s[KEEP_W-1:0] = acc_r;
        idx_s           = IW'(cnt_r);
        for (int i = 0; i < KEEP_W; i++) begin
            if (s_axis_tkeep[i]) begin
                comb_s[idx_s] = in_lanes_s[i];
                idx_s         = idx_s + IW'(1);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Packer FSM, accumulator, output register and packet statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RUN;
            acc_r          <= '0;
            cnt_r          <= '0;
            sop_r          <= 1'b1;
            user_r         <= '0;
            pkt_cnt_r      <= '0;
            last_lanes_r   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tkeep   <= '0;
            m_axis_tuser   <= '0;
            m_axis_tlast   <= 1'b0;
            stat_pkt_done  <= 1'b0;
            stat_pkt_lanes <= '0;
        end else begin
            stat_pkt_done <= tail_hs_s;
            if (tail_hs_s) begin
                stat_pkt_lanes <= last_lanes_r;
            end else begin
                stat_pkt_lanes <= stat_pkt_lanes;
            end

            case (state_r)
                RUN: begin
                    if (accept_s) begin
                        sop_r        <= s_axis_tlast;
                        user_r       <= user_s;
                        m_axis_tuser <= user_s;
                        // The count of a finished packet is parked until its
                        // tlast beat actually leaves the output register.
                        if (s_axis_tlast) begin
                            last_lanes_r <= pkt_next_s;
                            pkt_cnt_r    <= '0;
                        end else begin
                            pkt_cnt_r    <= pkt_next_s;
                        end

                        if (!s_axis_tlast && (total_s < TW'(KEEP_W))) begin
                            m_axis_tvalid <= 1'b0;
                            acc_r         <= comb_s[KEEP_W-1:0];
                            cnt_r         <= CW'(total_s);
                        end else if (s_axis_tlast && (total_s <= TW'(KEEP_W))) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= comb_s[KEEP_W-1:0];
                            m_axis_tkeep  <= keep_mask(total_s);
                            m_axis_tlast  <= 1'b1;
                            acc_r         <= '0;
                            cnt_r         <= '0;
                        end else begin
                            // Full beat out; residue above lane KEEP_W-1 is held.
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= comb_s[KEEP_W-1:0];
                            m_axis_tkeep  <= {KEEP_W{1'b1}};
                            m_axis_tlast  <= 1'b0;
                            acc_r         <= comb_s[2*KEEP_W-1:KEEP_W];
                            cnt_r         <= CW'(total_s - TW'(KEEP_W));
                            if (s_axis_tlast) begin
                                state_r <= FLUSH;
                            end else begin
                                state_r <= RUN;
                            end
                        end
                    end else if (free_s) begin
                        m_axis_tvalid <= 1'b0;
                    end else begin
                        m_axis_tvalid <= m_axis_tvalid;
                    end
                end

                FLUSH: begin
                    if (free_s) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= acc_r;
                        m_axis_tkeep  <= keep_mask(TW'(cnt_r));
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= user_r;
                        acc_r         <= '0;
                        cnt_r         <= '0;
                        state_r       <= RUN;
                    end else begin
                        state_r       <= FLUSH;
                    end
                end

                default: begin
                    state_r       <= RUN;
                    acc_r         <= '0;
                    cnt_r         <= '0;
                    sop_r         <= 1'b1;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_keep_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_keep_packer
//
// Scoreboard bench for axis_keep_packer (64-bit data, 8 byte lanes). A lane
// queue reference model turns every accepted input beat into expected output
// beats and packet lane counts; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_axis_keep_packer;

    localparam int DATA_W = 64;
    localparam int LANE_W = 8;
    localparam int KEEP_W = 8;
    localparam int USER_W = 1;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic [USER_W-1:0] s_axis_tuser;
    logic              s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic [USER_W-1:0] m_axis_tuser;
    logic              m_axis_tlast;
    logic              stat_pkt_done;
    logic [CNT_W-1:0]  stat_pkt_lanes;

    always #5 clk = ~clk;

    axis_keep_packer #(
        .DATA_W(DATA_W), .LANE_W(LANE_W), .KEEP_W(KEEP_W),
        .USER_W(USER_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .stat_pkt_done(stat_pkt_done), .stat_pkt_lanes(stat_pkt_lanes)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state and scoreboard queues.
    logic [7:0]  lq[$];
    logic [63:0] ed[$];
    logic [7:0]  ek[$];
    logic        el[$];
    logic        eu[$];
    int          elanes[$];
    logic        sop_m  = 1'b1;
    logic        user_m = 1'b0;
    int          pkt_m  = 0;

    task automatic emit(input int n, input logic last);
        logic [63:0] d;
        logic [7:0]  k;
        d = '0;
        k = '0;
        for (int i = 0; i < n; i++) begin
            d[i*8 +: 8] = lq.pop_front();
            k[i]        = 1'b1;
        end
        ed.push_back(d);
        ek.push_back(k);
        el.push_back(last);
        eu.push_back(user_m);
    endtask

    task automatic model_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic u, input logic l);
        if (sop_m) user_m = u;
        sop_m = l;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                lq.push_back(d[i*8 +: 8]);
                pkt_m++;
            end
        end
        if (pkt_m > 65535) pkt_m = 65535;
        while (lq.size() > 8 || (lq.size() == 8 && !l)) emit(8, 1'b0);
        if (l) begin
            emit(lq.size(), 1'b1);
            elanes.push_back(pkt_m);
            pkt_m = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [63:0] d, input logic [7:0] k,
                        input logic u, input logic l);
        int guard;
        guard         = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        while (!s_axis_tready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready", s_axis_tready, 1'b1);
        model_beat(d, k, u, l);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((ed.size() != 0 || elanes.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_beats", 64'(ed.size()), 64'd0);
        chk("drain_lanes", 64'(elanes.size()), 64'd0);
    endtask

    // Output backpressure: 0 = always ready, 1 = random, 2 = stalled.
    int bp_mode = 0;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: scoreboard compare, stall stability and stat pulse check.
    logic        stall_prev = 1'b0;
    logic [63:0] p_data;
    logic [7:0]  p_keep;
    logic        p_user, p_last;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_data", m_axis_tdata, p_data);
                chk("stall_keep", m_axis_tkeep, p_keep);
                chk("stall_user", m_axis_tuser, p_user);
                chk("stall_last", m_axis_tlast, p_last);
            end
            if (m_axis_tvalid && !m_axis_tready) chk("stall_s_ready", s_axis_tready, 1'b0);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_expected", 64'(ed.size() != 0), 64'd1);
                if (ed.size() != 0) begin
                    chk("out_data", m_axis_tdata, ed.pop_front());
                    chk("out_keep", m_axis_tkeep, ek.pop_front());
                    chk("out_last", m_axis_tlast, el.pop_front());
                    chk("out_user", m_axis_tuser, eu.pop_front());
                end
            end
            if (stat_pkt_done) begin
                chk("done_expected", 64'(elanes.size() != 0), 64'd1);
                if (elanes.size() != 0) chk("pkt_lanes", stat_pkt_lanes, 64'(elanes.pop_front()));
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            p_data = m_axis_tdata;
            p_keep = m_axis_tkeep;
            p_user = m_axis_tuser;
            p_last = m_axis_tlast;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_m_data"}, m_axis_tdata, 64'd0);
        chk({tag, "_m_keep"}, m_axis_tkeep, 8'd0);
        chk({tag, "_m_user"}, m_axis_tuser, 1'b0);
        chk({tag, "_m_last"}, m_axis_tlast, 1'b0);
        chk({tag, "_done"}, stat_pkt_done, 1'b0);
        chk({tag, "_lanes"}, stat_pkt_lanes, 16'd0);
    endtask

    localparam logic [63:0] SEQ = 64'h0706050403020100;

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_s_ready", s_axis_tready, 1'b1);
        rst = 1'b0;

        // Sparse single beat: A5 -> 0F, bytes {07,05,02,00}, 4 lanes.
        send(SEQ, 8'hA5, 1'b1, 1'b1);
        drain();

        // Unaligned head/tail: F0, FF, 0F -> FF, FF(last), 16 lanes.
        send(SEQ, 8'hF0, 1'b0, 1'b0);
        send(SEQ, 8'hFF, 1'b1, 1'b0);
        send(SEQ, 8'h0F, 1'b1, 1'b1);
        drain();

        // FLUSH split: FE then 0F last -> FF then 07; one-cycle input bubble.
        send(SEQ, 8'hFE, 1'b1, 1'b0);
        send(SEQ, 8'h0F, 1'b0, 1'b1);
        chk("flush_bubble", s_axis_tready, 1'b0);
        @(negedge clk);
        chk("flush_resume", s_axis_tready, 1'b1);
        drain();

        // Zero-keep beats and empty packet.
        send(SEQ, 8'h07, 1'b0, 1'b0);
        send(SEQ, 8'h00, 1'b1, 1'b0);
        send(SEQ, 8'h00, 1'b1, 1'b1);
        send(SEQ, 8'h00, 1'b1, 1'b1);
        drain();

        // Backpressure: output stalled for 5 cycles mid-packet.
        fork
            begin
                send(SEQ, 8'hF0, 1'b1, 1'b0);
                send(SEQ, 8'hFF, 1'b0, 1'b0);
                send(SEQ, 8'h3C, 1'b0, 1'b0);
                send(SEQ, 8'hFF, 1'b0, 1'b0);
                send(SEQ, 8'h0F, 1'b0, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                bp_mode = 2;
                repeat (5) @(negedge clk);
                bp_mode = 0;
            end
        join
        drain();

        // Reset with 3 lanes held: outputs clear, next packet is clean.
        send(SEQ, 8'h07, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        lq.delete();
        sop_m = 1'b1;
        pkt_m = 0;
        rst   = 1'b0;
        send(SEQ, 8'hFF, 1'b1, 1'b1);
        drain();

        // Random packets under random backpressure.
        bp_mode = 1;
        for (int p = 0; p < 25; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                logic [7:0] k;
                k = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                send({$urandom, $urandom}, k, 1'($urandom), b == nb - 1);
            end
        end
        drain();
        bp_mode = 0;

        // Lane counter saturation: 8201 full beats = 65608 lanes.
        for (int b = 0; b < 8200; b++) send(SEQ, 8'hFF, 1'b0, 1'b0);
        send(SEQ, 8'hFF, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
